// File: rtl/elm_pkg.sv
// rtl/elm_pkg.sv - shared states, default sizes and helpers for the ELM read sequencer
package elm_pkg;

  localparam int ELM_NUM_PATTERNS = 16;
  localparam int ELM_NUM_NEURONS  = 64;
  localparam int ELM_ADD_LAT      = 4;
  localparam int ELM_N_LFSR       = 12;
  localparam int DATA_W           = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FIFO,
    S_STEP,
    S_WAIT_ADD,
    S_EMIT,
    S_POP,
    S_DONE
  } elm_state_e;

  // Index width that stays legal when a count collapses to 1.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/elm_lat_cnt.sv
// rtl/elm_lat_cnt.sv - loadable down-counter with zero flag for pipeline-latency waits
module elm_lat_cnt #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Saturates at zero so a late decrement cannot wrap around.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/elm_read_seq.sv
// rtl/elm_read_seq.sv - per-pattern read sequencer: steps the LFSRs, waits the adder, emits neuron results
module elm_read_seq
  import elm_pkg::*;
#(
  parameter  int NUM_PATTERNS = ELM_NUM_PATTERNS,
  parameter  int NUM_NEURONS  = ELM_NUM_NEURONS,
  parameter  int ADD_LAT      = ELM_ADD_LAT,
  parameter  int N_LFSR       = ELM_N_LFSR,
  localparam int PAT_W        = idx_w(NUM_PATTERNS),
  localparam int NEU_W        = idx_w(NUM_NEURONS),
  localparam int CNT_W        = idx_w(ADD_LAT)
) (
  input  logic              clk2,
  input  logic              reset_an2,
  input  logic              start,
  input  logic              abort,
  input  logic              rempty,
  output logic              fifo_readcounter,
  output logic [N_LFSR-1:0] en_lfsr,
  input  logic [DATA_W-1:0] out_stimulus,
  output logic [DATA_W-1:0] h_data,
  output logic              h_valid,
  input  logic              h_ready,
  output logic [PAT_W-1:0]  pat_idx,
  output logic [NEU_W-1:0]  neu_idx,
  output logic              busy,
  output logic              done
);

  elm_state_e        r_state, w_state_nxt;
  logic [PAT_W-1:0]  r_pat_idx, w_pat_nxt;
  logic [NEU_W-1:0]  r_neu_idx, w_neu_nxt;
  logic [DATA_W-1:0] r_h_data;
  logic              w_cnt_load, w_cnt_dec, w_cnt_zero, w_capture;
  logic              w_neu_last, w_pat_last;

  elm_lat_cnt #(.W(CNT_W)) u_lat_cnt (
    .i_clk      (clk2),
    .i_rst_n    (reset_an2),
    .i_load     (w_cnt_load),
    .i_load_val (CNT_W'(ADD_LAT - 1)),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  assign w_neu_last = (int'(r_neu_idx) >= NUM_NEURONS - 1);
  assign w_pat_last = (int'(r_pat_idx) >= NUM_PATTERNS - 1);

  always_ff @(posedge clk2 or negedge reset_an2) begin
    if (!reset_an2) begin
      r_state   <= S_IDLE;
      r_pat_idx <= '0;
      r_neu_idx <= '0;
      r_h_data  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pat_idx <= w_pat_nxt;
      r_neu_idx <= w_neu_nxt;
      if (w_capture) r_h_data <= out_stimulus;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pat_nxt   = r_pat_idx;
    w_neu_nxt   = r_neu_idx;
    w_cnt_load  = 1'b0;
    w_cnt_dec   = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_pat_nxt = '0;
        w_neu_nxt = '0;
        if (start) w_state_nxt = S_WAIT_FIFO;
      end
      // FIFO head stays stable until the pop, so no separate load cycle.
      S_WAIT_FIFO: if (!rempty) w_state_nxt = S_STEP;
      S_STEP: begin
        w_cnt_load  = 1'b1;
        w_state_nxt = S_WAIT_ADD;
      end
      S_WAIT_ADD: begin
        w_cnt_dec = 1'b1;
        if (w_cnt_zero) begin
          w_capture   = 1'b1;
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        if (h_ready) begin
          if (!w_neu_last) begin
            w_neu_nxt   = r_neu_idx + NEU_W'(1);
            w_state_nxt = S_STEP;
          end else begin
            w_state_nxt = S_POP;
          end
        end
      end
      S_POP: begin
        w_neu_nxt = '0;
        if (!w_pat_last) begin
          w_pat_nxt   = r_pat_idx + PAT_W'(1);
          w_state_nxt = S_WAIT_FIFO;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // Abort overrides everything; a pop already decoded this cycle still happens.
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_pat_nxt   = '0;
      w_neu_nxt   = '0;
      w_capture   = 1'b0;
    end
  end

  assign en_lfsr          = {N_LFSR{r_state == S_STEP}};
  assign fifo_readcounter = (r_state == S_POP);
  assign h_valid          = (r_state == S_EMIT);
  assign busy             = (r_state != S_IDLE);
  assign done             = (r_state == S_DONE);
  assign h_data           = r_h_data;
  assign pat_idx          = r_pat_idx;
  assign neu_idx          = r_neu_idx;

endmodule

// File: tb/tb_elm_read_seq.sv
// tb/tb_elm_read_seq.sv - randomized self-checking bench for elm_read_seq
module tb_elm_read_seq;

  localparam int NP = 2, NN = 3, AL = 4, NL = 12, HIST = 1024;
  localparam int RUN_CYC = 2 + NP * (NN * (AL + 2) + 1);

  logic          clk2 = 1'b0, reset_an2 = 1'b0, start = 1'b0, abort = 1'b0;
  logic          rempty = 1'b1, h_ready = 1'b1;
  logic [15:0]   out_stimulus = 16'h0;
  logic          fifo_readcounter, h_valid, busy, done;
  logic [NL-1:0] en_lfsr;
  logic [15:0]   h_data;
  logic [0:0]    pat_idx;
  logic [1:0]    neu_idx;

  always #5 clk2 = ~clk2;

  elm_read_seq #(.NUM_PATTERNS(NP), .NUM_NEURONS(NN), .ADD_LAT(AL), .N_LFSR(NL)) dut (
    .clk2(clk2), .reset_an2(reset_an2), .start(start), .abort(abort), .rempty(rempty),
    .fifo_readcounter(fifo_readcounter), .en_lfsr(en_lfsr), .out_stimulus(out_stimulus),
    .h_data(h_data), .h_valid(h_valid), .h_ready(h_ready), .pat_idx(pat_idx),
    .neu_idx(neu_idx), .busy(busy), .done(done)
  );

  int n_checks = 0, n_fail = 0, cyc = 0;
  int n_step, n_pop, n_done, n_emit, n_en_bad, first_step, done_cyc;
  bit prev_vld;
  logic [15:0] stim_drv [HIST];
  int          step_q[$], lat_q[$], exp_neu_q[$], got_neu_q[$], exp_pat_q[$], got_pat_q[$];
  logic [15:0] exp_q[$], got_q[$];

  task automatic reset_model();
    n_step = 0; n_pop = 0; n_done = 0; n_emit = 0; n_en_bad = 0;
    first_step = -1; done_cyc = -1; prev_vld = 1'b0;
    step_q.delete(); lat_q.delete(); exp_q.delete(); got_q.delete();
    exp_neu_q.delete(); got_neu_q.delete(); exp_pat_q.delete(); got_pat_q.delete();
  endtask

  // Advance one clock, sample away from the edge, then drive a fresh random adder value.
  // A result emitted at sample c must be the adder value that was present AL+1 edges after its step.
  task automatic cycle();
    int s;
    @(posedge clk2);
    cyc++;
    #1;
    if (en_lfsr !== '0) begin
      n_step++;
      if (en_lfsr !== '1) n_en_bad++;
      step_q.push_back(cyc);
      if (first_step < 0) first_step = cyc;
    end
    if (fifo_readcounter === 1'b1) n_pop++;
    if (done === 1'b1) begin n_done++; done_cyc = cyc; end
    if (h_valid === 1'b1 && !prev_vld) begin
      if (step_q.size() > 0) begin
        s = step_q.pop_front();
        exp_q.push_back(stim_drv[(s + AL) % HIST]);
        lat_q.push_back(cyc - s);
      end else begin
        exp_q.push_back(16'hxxxx);
        lat_q.push_back(-1);
      end
      got_q.push_back(h_data);
      exp_neu_q.push_back(n_emit % NN);
      exp_pat_q.push_back(n_emit / NN);
      got_neu_q.push_back(int'(neu_idx));
      got_pat_q.push_back(int'(pat_idx));
      n_emit++;
    end
    prev_vld = (h_valid === 1'b1);
    out_stimulus = 16'($urandom);
    stim_drv[cyc % HIST] = out_stimulus;
  endtask

  task automatic run_until_done(input int budget);
    for (int i = 0; i < budget && n_done == 0; i++) cycle();
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (fifo_readcounter !== 1'b0) begin n_fail++; $display("FAIL reset_pop: got %b want 0", fifo_readcounter); end
    n_checks++; if (en_lfsr !== '0) begin n_fail++; $display("FAIL reset_en_lfsr: got %h want 0", en_lfsr); end
    n_checks++; if (h_valid !== 1'b0) begin n_fail++; $display("FAIL reset_h_valid: got %b want 0", h_valid); end
    n_checks++; if (h_data !== 16'h0) begin n_fail++; $display("FAIL reset_h_data: got %h want 0", h_data); end
    n_checks++; if (pat_idx !== 1'b0) begin n_fail++; $display("FAIL reset_pat_idx: got %0d want 0", pat_idx); end
    n_checks++; if (neu_idx !== 2'd0) begin n_fail++; $display("FAIL reset_neu_idx: got %0d want 0", neu_idx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    stim_drv[0] = out_stimulus;
    @(negedge clk2);
    reset_an2 = 1'b1;
    repeat (2) cycle();
  endtask

  task automatic test_full_run();
    int s0;
    repeat (2) cycle();
    reset_model();
    rempty = 1'b0; h_ready = 1'b1;
    start = 1'b1; cycle(); start = 1'b0; s0 = cyc;
    run_until_done(200);
    n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL full_done_count: got %0d want 1", n_done); end
    n_checks++; if (done_cyc - s0 !== RUN_CYC) begin n_fail++; $display("FAIL full_done_time: got %0d want %0d", done_cyc - s0, RUN_CYC); end
    n_checks++; if (first_step - s0 !== 1) begin n_fail++; $display("FAIL full_first_step: got %0d want 1", first_step - s0); end
    n_checks++; if (n_step !== NP * NN) begin n_fail++; $display("FAIL full_steps: got %0d want %0d", n_step, NP * NN); end
    n_checks++; if (n_en_bad !== 0) begin n_fail++; $display("FAIL full_en_lfsr_value: got %0d partial pulses want 0", n_en_bad); end
    n_checks++; if (n_pop !== NP) begin n_fail++; $display("FAIL full_pops: got %0d want %0d", n_pop, NP); end
    n_checks++; if (n_emit !== NP * NN) begin n_fail++; $display("FAIL full_emits: got %0d want %0d", n_emit, NP * NN); end
    foreach (got_q[i]) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_h_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      n_checks++; if (lat_q[i] !== AL + 1) begin n_fail++; $display("FAIL full_latency[%0d]: got %0d want %0d", i, lat_q[i], AL + 1); end
      n_checks++; if (got_neu_q[i] !== exp_neu_q[i]) begin n_fail++; $display("FAIL full_neu_idx[%0d]: got %0d want %0d", i, got_neu_q[i], exp_neu_q[i]); end
      n_checks++; if (got_pat_q[i] !== exp_pat_q[i]) begin n_fail++; $display("FAIL full_pat_idx[%0d]: got %0d want %0d", i, got_pat_q[i], exp_pat_q[i]); end
    end
    cycle();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_idle_after_done: busy %b want 0", busy); end
  endtask

  task automatic test_stall();
    int s0, nst2, st;
    bit stalled;
    repeat (2) cycle();
    reset_model();
    nst2 = $urandom_range(2, 9);
    rempty = 1'b1; h_ready = 1'b1;
    start = 1'b1; cycle(); start = 1'b0; s0 = cyc;
    repeat (10) cycle();
    n_checks++; if (n_step !== 0 || n_pop !== 0) begin n_fail++; $display("FAIL stall_activity: steps %0d pops %0d want 0 0", n_step, n_pop); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy: got %b want 1", busy); end
    rempty = 1'b0;
    cycle();
    n_checks++; if (en_lfsr !== '1) begin n_fail++; $display("FAIL stall_first_step: en_lfsr %h want fff", en_lfsr); end
    stalled = 1'b0;
    for (int i = 0; i < 300 && n_done == 0; i++) begin
      cycle();
      if (n_pop == 1 && !stalled) begin
        stalled = 1'b1;
        rempty = 1'b1;
        st = n_step;
        repeat (nst2) cycle();
        n_checks++; if (n_step !== st) begin n_fail++; $display("FAIL stall2_steps: got %0d want %0d", n_step, st); end
        rempty = 1'b0;
      end
    end
    n_checks++; if (done_cyc - s0 !== RUN_CYC + 10 + nst2 - 1) begin n_fail++; $display("FAIL stall_done_time: got %0d want %0d", done_cyc - s0, RUN_CYC + 10 + nst2 - 1); end
    n_checks++; if (n_pop !== NP) begin n_fail++; $display("FAIL stall_pops: got %0d want %0d", n_pop, NP); end
    n_checks++; if (n_emit !== NP * NN) begin n_fail++; $display("FAIL stall_emits: got %0d want %0d", n_emit, NP * NN); end
    foreach (got_q[i]) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_h_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] hold;
    logic [1:0]  hn;
    int          st;
    repeat (2) cycle();
    reset_model();
    rempty = 1'b0; h_ready = 1'b1;
    start = 1'b1; cycle(); start = 1'b0;
    for (int i = 0; i < 30 && h_valid !== 1'b1; i++) cycle();
    n_checks++; if (h_valid !== 1'b1) begin n_fail++; $display("FAIL bp_reach_emit: h_valid %b want 1", h_valid); end
    h_ready = 1'b0;
    hold = h_data; hn = neu_idx; st = n_step;
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_checks++; if (h_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", k, h_valid); end
      n_checks++; if (h_data !== hold) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", k, h_data, hold); end
      n_checks++; if (neu_idx !== hn) begin n_fail++; $display("FAIL bp_neu_idx[%0d]: got %0d want %0d", k, neu_idx, hn); end
    end
    n_checks++; if (n_step !== st) begin n_fail++; $display("FAIL bp_no_step: got %0d want %0d", n_step, st); end
    for (int i = 0; i < 500 && n_done == 0; i++) begin
      h_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    h_ready = 1'b1;
    n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL bp_done: got %0d want 1", n_done); end
    n_checks++; if (n_emit !== NP * NN) begin n_fail++; $display("FAIL bp_emits: got %0d want %0d", n_emit, NP * NN); end
    foreach (got_q[i]) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_h_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_abort();
    bit found;
    repeat (2) cycle();
    reset_model();
    rempty = 1'b0; h_ready = 1'b1;
    start = 1'b1; cycle(); start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cycle();
      if (en_lfsr === '1 && pat_idx === 1'b1 && neu_idx === 2'd2) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL abort_reach_step: got 0 want 1"); end
    cycle();
    abort = 1'b1; cycle(); abort = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_checks++; if (pat_idx !== 1'b0 || neu_idx !== 2'd0) begin n_fail++; $display("FAIL abort_indices: got %0d/%0d want 0/0", pat_idx, neu_idx); end
    n_checks++; if (h_valid !== 1'b0) begin n_fail++; $display("FAIL abort_h_valid: got %b want 0", h_valid); end
    repeat (40) cycle();
    n_checks++; if (n_pop !== 1) begin n_fail++; $display("FAIL abort_pops: got %0d want 1", n_pop); end
    n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL abort_done: got %0d want 0", n_done); end
  endtask

  task automatic test_async_reset();
    repeat (2) cycle();
    reset_model();
    rempty = 1'b0; h_ready = 1'b1;
    start = 1'b1; cycle(); start = 1'b0;
    for (int i = 0; i < 30 && h_valid !== 1'b1; i++) cycle();
    n_checks++; if (h_valid !== 1'b1) begin n_fail++; $display("FAIL areset_reach_emit: h_valid %b want 1", h_valid); end
    #2 reset_an2 = 1'b0;
    #1;
    n_checks++; if (h_valid !== 1'b0) begin n_fail++; $display("FAIL areset_h_valid: got %b want 0", h_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy: got %b want 0", busy); end
    n_checks++; if (h_data !== 16'h0) begin n_fail++; $display("FAIL areset_h_data: got %h want 0", h_data); end
    n_checks++; if (pat_idx !== 1'b0 || neu_idx !== 2'd0) begin n_fail++; $display("FAIL areset_indices: got %0d/%0d want 0/0", pat_idx, neu_idx); end
    n_checks++; if (en_lfsr !== '0 || fifo_readcounter !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL areset_strobes: en %h pop %b done %b want 0 0 0", en_lfsr, fifo_readcounter, done); end
    @(negedge clk2);
    reset_an2 = 1'b1;
    repeat (2) cycle();
    reset_model();
    start = 1'b1; cycle(); start = 1'b0;
    run_until_done(200);
    n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL areset_rerun_done: got %0d want 1", n_done); end
    n_checks++; if (n_pop !== NP) begin n_fail++; $display("FAIL areset_rerun_pops: got %0d want %0d", n_pop, NP); end
    n_checks++; if (n_emit !== NP * NN) begin n_fail++; $display("FAIL areset_rerun_emits: got %0d want %0d", n_emit, NP * NN); end
    foreach (got_q[i]) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL areset_h_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_start_ignored();
    int s0;
    repeat (2) cycle();
    reset_model();
    rempty = 1'b0; h_ready = 1'b1;
    start = 1'b1; cycle(); start = 1'b0; s0 = cyc;
    for (int i = 0; i < 30; i++) begin
      start = ($urandom_range(0, 3) == 0);
      cycle();
    end
    start = 1'b0;
    run_until_done(200);
    n_checks++; if (done_cyc - s0 !== RUN_CYC) begin n_fail++; $display("FAIL busy_start_done_time: got %0d want %0d", done_cyc - s0, RUN_CYC); end
    start = 1'b1; cycle(); start = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL done_start_busy: got %b want 0", busy); end
    repeat (30) cycle();
    n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL start_ignored_done: got %0d want 1", n_done); end
    n_checks++; if (n_step !== NP * NN) begin n_fail++; $display("FAIL start_ignored_steps: got %0d want %0d", n_step, NP * NN); end
  endtask

  initial begin
    reset_model();
    test_reset();
    test_full_run();
    test_stall();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/elm_read_seq.md
# elm_read_seq

Read-side sequencer for the ELM hidden-layer datapath, clocked in the clk2 domain. For each input pattern it waits for the pattern FIFO to hold data and steps the random-weight generator once per hidden neuron. It waits out the weighted-pixel adder latency, then hands each neuron result to a downstream consumer over a valid/ready handshake. It pops the FIFO when all neurons of the pattern are done. It replaces the free-running en_lfsr*/fifo_readcounter inputs currently driven from the top level.

## Interface
- NUM_PATTERNS, default 16: patterns per run, ≥1.
- NUM_NEURONS, default 64: hidden neurons per pattern, ≥1.
- ADD_LAT, default 4: clk2 cycles from an en_lfsr step to a valid out_stimulus, ≥1.
- N_LFSR, default 12: number of LFSR enables.

Ports:
- clk2, in, 1: sole clock.
- reset_an2, in, 1: asynchronous, active-low reset.
- start, in, 1: one-cycle run request, honoured only in IDLE.
- abort, in, 1: synchronous abort of the current run.
- rempty, in, 1: FIFO empty flag (clk2 domain).
- fifo_readcounter, out, 1: FIFO pop strobe (rinc).
- en_lfsr, out, N_LFSR: LFSR step enables; bit k drives en_lfsr{k}.
- out_stimulus, in, 16: adder result.
- h_data, out, 16: captured neuron result.
- h_valid, out, 1: h_data valid.
- h_ready, in, 1: consumer accepts.
- pat_idx, out, clog2(NUM_PATTERNS): current pattern.
- neu_idx, out, clog2(NUM_NEURONS): current neuron.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse when a run completes normally.

## Operation
- States: IDLE, WAIT_FIFO, STEP, WAIT_ADD, EMIT, POP, DONE.
- IDLE:
  - start → WAIT_FIFO.
  - Clears pat_idx and neu_idx.
- WAIT_FIFO:
  - Stays while rempty=1.
  - rempty=0 → STEP.
  - The FIFO head (fifo_dataout) is valid and stays stable until the pop, so no load cycle is needed.
- STEP:
  - Exactly one cycle, with en_lfsr = all ones.
  - → WAIT_ADD, loading the latency counter with ADD_LAT−1.
- WAIT_ADD:
  - Decrements the counter each cycle.
  - When the counter is 0, captures out_stimulus into h_data on that edge → EMIT.
- EMIT:
  - h_valid=1 and h_data held stable until h_ready=1 (transfer on the edge where valid and ready are both high).
  - On transfer, if neu_idx < NUM_NEURONS−1: increment neu_idx → STEP.
  - Otherwise → POP.
- POP:
  - One cycle with fifo_readcounter=1.
  - Clears neu_idx.
  - If pat_idx < NUM_PATTERNS−1: increment pat_idx → WAIT_FIFO.
  - Otherwise → DONE.
- DONE: done=1 for one cycle → IDLE.
- abort:
  - From any non-IDLE state, → IDLE on the next edge; indices cleared; no pop issued.
  - If abort arrives in POP, that cycle's pop still occurs, since the strobe is combinational from the state.
  - abort takes priority over all other transitions.
- start outside IDLE is ignored.
- Simultaneous start and abort in IDLE: start wins, since abort has no effect in IDLE.
- Indices wrap only through POP or IDLE; neither index ever exceeds its parameter minus 1.

## Timing
- Reset values: state=IDLE; fifo_readcounter=0, en_lfsr=0, h_valid=0, h_data=0, pat_idx=0, neu_idx=0, busy=0, done=0.
- All outputs are registered, or decoded from the state register only; there is no combinational path from an input to any output.
- Per-neuron cost, with h_ready held high: 1 (STEP) + ADD_LAT (WAIT_ADD) + 1 (EMIT) cycles.
- Per-pattern cost: NUM_NEURONS × (ADD_LAT+2) + 1 (POP) cycles, plus any WAIT_FIFO stall.
- The first STEP occurs 2 cycles after start when the FIFO is non-empty.
- Reset mid-run: returns to IDLE immediately (asynchronous); the in-flight h_valid drops; the FIFO is not popped.

## Structure
- Shared package elm_pkg holds:
  - the state enumeration;
  - the default constants NUM_PATTERNS, NUM_NEURONS, ADD_LAT, N_LFSR;
  - the 16-bit result width.
- Sub-module elm_lat_cnt: a loadable down-counter with a zero flag, reusable for other pipeline-latency waits.
- Everything else is a single FSM with its index counters.

## Test plan
- NUM_PATTERNS=2, NUM_NEURONS=3, ADD_LAT=4, FIFO pre-filled, h_ready=1:
  - 6 h_valid pulses;
  - en_lfsr=12'hFFF for exactly 6 single cycles;
  - 2 fifo_readcounter pulses;
  - done 2 + 2×(3×6+1) = 40 cycles after start.
- rempty=1 for 10 cycles after start: no STEP or pop while stalled; the first STEP comes on the cycle after rempty falls.
- Backpressure: h_ready low for 5 cycles in EMIT: h_valid and h_data stay stable; neu_idx does not advance; no en_lfsr pulse.
- abort asserted in WAIT_ADD of pattern 1 neuron 2:
  - next cycle state is IDLE, busy=0, indices 0;
  - no further fifo_readcounter and no done pulse.
- Async reset pulse during EMIT: h_valid=0 and all outputs at reset values immediately, without waiting for a clock edge; a new start then runs cleanly.
- start during busy and start coincident with DONE: both ignored; exactly one done per accepted start.
